vdc_angle_gen: RTL
==================

# vdc_angle_gen

Sequential generator of base-`BASE` Van der Corput fractions, each scaled to a 16-bit angle code where 0..65535 maps to 0..2π. It sits directly upstream of the 16-bit trig lookup stage: `angle` drives that stage's angle input and `out_valid` drives its `start`. Together they produce low-discrepancy points on the unit circle. An internal sequence index `k` auto-increments after each accepted output and can be reseeded.

## Interface
- `BASE`, default 2: radix of the sequence; legal range 2..16, checked at elaboration.
- `clk`  in  1: single clock, all logic on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `load`  in  1: reseed request; honoured only in IDLE.
- `k_in`  in  16: new index value, captured when `load` is honoured.
- `req`  in  1: request the next angle; honoured only in IDLE when `load` is low.
- `angle`  out  16: Van der Corput fraction of the current `k`, as floor(vdc(k)·65536).
- `out_valid`  out  1: `angle` is valid and held.
- `out_ready`  in  1: downstream accepts `angle`.
- `busy`  out  1: high in every state except IDLE.
- `k_cur`  out  16: current sequence index.

## Operation
- **Reset values:** `angle`=0, `out_valid`=0, `busy`=0, `k_cur`=0, state=IDLE. Internal `q`, `num`, `den` and the divider registers are all cleared.
- **IDLE:**
  - `load`=1: `k` ← `k_in`; stay in IDLE. `load` has priority over `req` on the same cycle.
  - Else `req`=1: `q` ← `k`, `num` ← 0, `den` ← 1; go to DIGITS.
- **DIGITS**, one cycle per base-`BASE` digit, least significant digit first:
  - If `q`≠0: `d` = `q` mod `BASE`, `q` ← `q` / `BASE`, `num` ← `num`·`BASE` + `d`, `den` ← `den`·`BASE`.
  - If `q`=0: go to DIVIDE and initialise the divider with `num` and `den`.
  - Division and modulo are by the constant `BASE` and are combinational.
- **DIVIDE:** 16-iteration restoring division producing quotient = floor(`num`·2^16 / `den`). The invariant `num` < `den` holds, so the quotient fits in 16 bits. After the 16th iteration, register the quotient into `angle`, set `out_valid`=1 and go to OUT.
- **OUT:** `angle` and `out_valid` are held while `out_ready`=0. On `out_ready`=1: `out_valid` ← 0, `k` ← `k`+1 with a 16-bit wrap (65535→0), return to IDLE.
- **Width rules:**
  - `q` is 16 bits.
  - `num` and `den` are 21 bits. Bound: `BASE`^ndigits ≤ 16·65535 < 2^20.
  - The divider remainder is 21 bits.
- `load` and `req` are ignored in any state other than IDLE. They are not queued.
- **Reset mid-operation:** `rst_n`=0 in any state returns all outputs and state to their reset values on the next edge. Any partial result is discarded.

## Timing
- Let n = number of base-`BASE` digits of `k`, with n=0 for `k`=0.
- `out_valid` rises n+17 clock edges after the edge that sampled `req` in IDLE.
  - `k`=0: 17 edges.
  - `k`=1, base 2: 18 edges.
  - Worst case for base 2 (`k`=0xFFFF): 33 edges.
- Minimum spacing between results is n+19 cycles, assuming `out_ready` is tied high and `req` is reasserted immediately. This breaks down as 1 IDLE cycle, then n+17 cycles through DIGITS and DIVIDE, then 1 OUT cycle.
- `busy` is registered. It goes high on the edge after `req` is accepted and low on the edge where the OUT handshake completes.

## Structure
- Shared package `lds_pkg` contains:
  - `ANGLE_W`=16, `K_W`=16, `ACC_W`=21.
  - `vdc_state_t` enum {IDLE, DIGITS, DIVIDE, OUT}.
- One sub-module, `frac_div16`: the iterative restoring divider.
  - Ports: `clk`, `rst_n`, `start`, `num[20:0]`, `den[20:0]`, `quot[15:0]`, `done`.
  - `done` pulses for one cycle on the 16th iteration.
  - Reusable by other sequence generators that need the same fraction scaling.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, then release → all outputs 0 and state IDLE. Then `req` → `angle`=0x0000 (k=0), `out_valid` asserted exactly 17 edges after the `req` edge.
- **Base 2, k=0..3:** `out_ready`=1 and `req` pulsed for each point → `angle` sequence 0x0000, 0x8000, 0x4000, 0xC000; `k_cur` ends at 4.
- **Base 3, reseed:** `load` with `k_in`=1, then `req` → `angle`=0x5555. Next `req` (k=2) → 0xAAAA.
- **Backpressure:** hold `out_ready`=0 for 10 cycles → `angle` and `out_valid` stable; `req` and `load` pulses during this time are ignored; `k_cur` unchanged. Release → `k` increments exactly once.
- **Wrap and priority:** `load` with `k_in`=0xFFFF, base 2 → `angle`=0xFFFF after 33 edges. After the handshake `k_cur`=0x0000. `load` and `req` high on the same IDLE cycle → only the load takes effect; `busy` stays 0.
- **Mid-operation reset:** assert `rst_n`=0 during DIVIDE → next edge `busy`=0, `out_valid`=0, `k_cur`=0. No stale `angle` appears afterwards.

Source files
------------

// File: rtl/lds_pkg.sv
// Shared types and widths for the low-discrepancy angle generators.
// Holds the index/angle/accumulator widths and the generator state encoding.
package lds_pkg;

    localparam int ANGLE_W = 16;
    localparam int K_W     = 16;
    localparam int ACC_W   = 21;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIGITS = 2'd1,
        DIVIDE = 2'd2,
        OUT    = 2'd3
    } vdc_state_t;

endpackage

// File: rtl/vdc_angle_gen_if.sv
// Request/result bus of the Van der Corput angle generator.
// The slave side is the generator, the master side is its controller.
interface vdc_angle_gen_if;
    import lds_pkg::*;

    logic               load;
    logic [K_W-1:0]     k_in;
    logic               req;
    logic [ANGLE_W-1:0] angle;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic [K_W-1:0]     k_cur;

    modport master (
        output load, k_in, req, out_ready,
        input  angle, out_valid, busy, k_cur
    );

    modport slave (
        input  load, k_in, req, out_ready,
        output angle, out_valid, busy, k_cur
    );
endinterface

// File: rtl/frac_div16.sv
// Iterative restoring divider giving floor(num * 2^16 / den), one quotient bit
// per cycle; requires num < den so the quotient fits in 16 bits.
module frac_div16
    import lds_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ACC_W-1:0]   num,
    input  logic [ACC_W-1:0]   den,
    output logic [ANGLE_W-1:0] quot,
    output logic               done
);

    logic [ACC_W-1:0]   rem_q;
    logic [ACC_W-1:0]   den_q;
    logic [ANGLE_W-2:0] quot_q;
    logic [3:0]         cnt_q;
    logic               run_q;

    logic [ACC_W:0]     shifted_s;
    logic [ACC_W-1:0]   rem_sh_s;
    logic [ACC_W-1:0]   rem_next_s;
    logic               fits_s;

    // Trial subtraction for the current quotient bit; rem < den keeps the result in ACC_W bits.
    always_comb begin
        shifted_s = {rem_q, 1'b0};
        rem_sh_s  = {rem_q[ACC_W-2:0], 1'b0};
        fits_s    = (shifted_s >= {1'b0, den_q});
        if (fits_s) begin
            rem_next_s = rem_sh_s - den_q;
        end else begin
            rem_next_s = rem_sh_s;
        end
    end

    // The last bit is presented combinationally so the caller can register the full quotient on done.
    assign quot = {quot_q, fits_s};
    assign done = run_q && (cnt_q == 4'd15);

    // Divider iteration state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= {ACC_W{1'b0}};
            den_q  <= {ACC_W{1'b0}};
            quot_q <= {(ANGLE_W-1){1'b0}};
            cnt_q  <= 4'd0;
            run_q  <= 1'b0;
        end else if (start) begin
            rem_q  <= num;
            den_q  <= den;
            quot_q <= {(ANGLE_W-1){1'b0}};
            cnt_q  <= 4'd0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            rem_q  <= rem_next_s;
            quot_q <= {quot_q[ANGLE_W-3:0], fits_s};
            cnt_q  <= cnt_q + 4'd1;
            run_q  <= (cnt_q != 4'd15);
        end else begin
            rem_q  <= rem_q;
            den_q  <= den_q;
            quot_q <= quot_q;
            cnt_q  <= cnt_q;
            run_q  <= run_q;
        end
    end

endmodule

// File: rtl/vdc_angle_gen.sv
// Base-BASE Van der Corput sequence generator producing 16-bit angle codes
// (0..65535 = 0..2pi) for the downstream trig lookup stage.
module vdc_angle_gen
    import lds_pkg::*;
#(
    parameter int BASE = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    vdc_angle_gen_if.slave bus
);

    generate
        if (BASE < 2 || BASE > 16) begin : g_bad_base
            $error("vdc_angle_gen: BASE must lie in 2..16");
        end
    endgenerate

    localparam logic [K_W-1:0]   BASE_K = K_W'(BASE);
    localparam logic [ACC_W-1:0] BASE_A = ACC_W'(BASE);

    vdc_state_t         state_q;
    logic [K_W-1:0]     k_q;
    logic [K_W-1:0]     q_q;
    logic [ACC_W-1:0]   num_q;
    logic [ACC_W-1:0]   den_q;
    logic [ANGLE_W-1:0] angle_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [K_W-1:0]     q_div_s;
    logic [ACC_W-1:0]   digit_s;
    logic [ACC_W-1:0]   num_next_s;
    logic [ACC_W-1:0]   den_next_s;
    logic               div_start_s;
    logic [ANGLE_W-1:0] div_quot_s;
    logic               div_done_s;

    // Digit extraction by the constant radix; num accumulates the reversed digits.
    always_comb begin
        q_div_s     = q_q / BASE_K;
        digit_s     = ACC_W'(q_q % BASE_K);
        num_next_s  = (num_q * BASE_A) + digit_s;
        den_next_s  = den_q * BASE_A;
        div_start_s = (state_q == DIGITS) && (q_q == {K_W{1'b0}});
    end

    frac_div16 u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start_s),
        .num   (num_q),
        .den   (den_q),
        .quot  (div_quot_s),
        .done  (div_done_s)
    );

    // Sequencer: reseed/request in IDLE, digit reversal, divide, then hold until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= {K_W{1'b0}};
            q_q         <= {K_W{1'b0}};
            num_q       <= {ACC_W{1'b0}};
            den_q       <= {ACC_W{1'b0}};
            angle_q     <= {ANGLE_W{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.load) begin
                        k_q <= bus.k_in;
                    end else if (bus.req) begin
                        q_q     <= k_q;
                        num_q   <= {ACC_W{1'b0}};
                        den_q   <= ACC_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= DIGITS;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DIGITS: begin
                    if (q_q != {K_W{1'b0}}) begin
                        q_q   <= q_div_s;
                        num_q <= num_next_s;
                        den_q <= den_next_s;
                    end else begin
                        state_q <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (div_done_s) begin
                        angle_q     <= div_quot_s;
                        out_valid_q <= 1'b1;
                        state_q     <= OUT;
                    end else begin
                        state_q <= DIVIDE;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        k_q         <= k_q + 16'd1;
                        state_q     <= IDLE;
                    end else begin
                        state_q <= OUT;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.angle     = angle_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.k_cur     = k_q;

endmodule
